// File: rtl/add_sub_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : add_sub_seq
//  Purpose  : Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per clock,
//             with start/busy/done handshake and carry/overflow/zero flags.
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_STEPS = WIDTH / DIGIT;
    localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_mode;
    logic [c_CW-1:0]  r_step;

    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;
    logic             w_ovf;

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Sum digits enter at the MSB end so the full word is aligned after N steps.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign w_acc_next = w_dsum[DIGIT-1:0];
        end else begin : g_shift
            assign w_acc_next = {w_dsum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_step == c_CW'(c_STEPS - 1));

    // On the last step the operand registers hold the sign bits in bit DIGIT-1.
    assign w_ovf = (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_dsum[DIGIT-1] != r_a[DIGIT-1]);

    assign ready = (r_state == S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
            r_step  <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_mode  <= sub;
                        r_step  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dsum[DIGIT];
                    r_step  <= r_step + c_CW'(1);
                    if (w_last) begin
                        s       <= w_acc_next;
                        cout    <= w_dsum[DIGIT] ^ r_mode;
                        ovf     <= w_ovf;
                        zero    <= (w_acc_next == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
